// File: rtl/mode_select_ctrl.sv
// Front-panel mode selector: sample-tick generator, per-button sync/debounce/edge FSM,
// wrap-around mode index. Define HOLD_REPEAT_EN to add hold-to-auto-repeat.
module mode_select_ctrl #(
  parameter int NUM_MODES    = 4,
  parameter int TICK_DIV     = 524288,
  parameter int DEBOUNCE_N   = 2,
  parameter int RESET_SEL    = 0,
  parameter int REPEAT_DELAY = 10,
  parameter int REPEAT_RATE  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         next_n,
  input  logic                         prev_n,
  output logic [$clog2(NUM_MODES)-1:0] sel,
  output logic                         sel_changed,
  output logic                         tick
);

  localparam int SEL_W = $clog2(NUM_MODES);
  localparam int TW    = $clog2(TICK_DIV);
  localparam int DW    = $clog2(DEBOUNCE_N + 1);

  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0]    DB_LAST   = DW'(DEBOUNCE_N);
  localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(NUM_MODES - 1);
  localparam logic [SEL_W-1:0] SEL_RST   = SEL_W'(RESET_SEL);

  if (NUM_MODES < 2 || NUM_MODES > 16 || TICK_DIV < 2 || DEBOUNCE_N < 1 ||
      RESET_SEL < 0 || RESET_SEL >= NUM_MODES ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("mode_select_ctrl: illegal parameter value");
  end

`ifdef HOLD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LD  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;

  logic [RW-1:0] rep_cnt [2];
  logic [RW-1:0] rep_nxt [2];
`else
  typedef enum logic {IDLE, PRESSED} state_t;
`endif

  // Tick strobe is registered so it is glitch-free for downstream display blocks.
  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick     <= (tick_cnt == TICK_LAST);
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
    end
  end

  // Channel index 0 = next, 1 = prev; all per-button signals are pressed-high.
  logic [1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~{prev_n, next_n};
      sync2 <= sync1;
    end
  end

  logic [1:0]    cand, cand_nxt, db;
  logic [DW-1:0] stab_cnt [2];
  logic [DW-1:0] cnt_nxt  [2];

  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = stab_cnt;
    for (int i = 0; i < 2; i++) begin
      if (sync2[i] == cand[i]) begin
        cnt_nxt[i] = (stab_cnt[i] == DB_LAST) ? stab_cnt[i] : stab_cnt[i] + DW'(1);
      end else begin
        cand_nxt[i] = sync2[i];
        cnt_nxt[i]  = DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand <= '0;
      db   <= '0;
      for (int i = 0; i < 2; i++) stab_cnt[i] <= '0;
    end else if (tick) begin
      cand <= cand_nxt;
      for (int i = 0; i < 2; i++) begin
        stab_cnt[i] <= cnt_nxt[i];
        if (cnt_nxt[i] == DB_LAST) db[i] <= cand_nxt[i];
      end
    end
  end

  // Press FSM: state | meaning
  //   IDLE    | debounced level released, waiting for a press
  //   PRESSED | press accepted and stepped once, waiting for release
  //   REPEAT  | (HOLD_REPEAT_EN) held past the initial delay, stepping at the repeat rate
  state_t     state     [2];
  state_t     state_nxt [2];
  logic [1:0] step;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= IDLE;
`ifdef HOLD_REPEAT_EN
        rep_cnt[i] <= '0;
`endif
      end
    end else begin
      state <= state_nxt;
`ifdef HOLD_REPEAT_EN
      rep_cnt <= rep_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    step      = '0;
`ifdef HOLD_REPEAT_EN
    rep_nxt = rep_cnt;
`endif
    for (int i = 0; i < 2; i++) begin
      case (state[i])
        IDLE: begin
          if (db[i]) begin
            state_nxt[i] = PRESSED;
            step[i]      = 1'b1;
`ifdef HOLD_REPEAT_EN
            rep_nxt[i] = DELAY_LD;
`endif
          end
        end
        PRESSED: begin
          if (!db[i]) begin
            state_nxt[i] = IDLE;
          end
`ifdef HOLD_REPEAT_EN
          else if (tick) begin
            if (rep_cnt[i] == '0) begin
              step[i]      = 1'b1;
              state_nxt[i] = REPEAT;
              rep_nxt[i]   = RATE_LD;
            end else begin
              rep_nxt[i] = rep_cnt[i] - RW'(1);
            end
          end
`endif
        end
`ifdef HOLD_REPEAT_EN
        REPEAT: begin
          if (!db[i]) begin
            state_nxt[i] = IDLE;
          end else if (tick) begin
            if (rep_cnt[i] == '0) begin
              step[i]    = 1'b1;
              rep_nxt[i] = RATE_LD;
            end else begin
              rep_nxt[i] = rep_cnt[i] - RW'(1);
            end
          end
        end
`endif
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // Opposing requests in the same cycle cancel each other.
  logic [SEL_W-1:0] sel_nxt;
  logic             chg_nxt;

  always_comb begin
    sel_nxt = sel;
    chg_nxt = 1'b0;
    if (step[0] && !step[1]) begin
      sel_nxt = (sel == SEL_MAX) ? '0 : sel + SEL_W'(1);
      chg_nxt = 1'b1;
    end else if (step[1] && !step[0]) begin
      sel_nxt = (sel == '0) ? SEL_MAX : sel - SEL_W'(1);
      chg_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel         <= SEL_RST;
      sel_changed <= 1'b0;
    end else begin
      sel         <= sel_nxt;
      sel_changed <= chg_nxt;
    end
  end

endmodule

// File: tb/tb_mode_select_ctrl.sv
// Self-checking bench for mode_select_ctrl: tick timing, clean presses, wrap, glitches,
// cancellation, reset behaviour and randomized press sequences against a modular-index model.
module tb_mode_select_ctrl;

  localparam int NM  = 5;
  localparam int TD  = 4;
  localparam int DBN = 2;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       next_n = 1'b1;
  logic       prev_n = 1'b1;
  logic [2:0] sel;
  logic       sel_changed;
  logic       tick;

  int errors    = 0;
  int checks    = 0;
  int model_sel = 0;
  int pulse_cnt = 0;
  int incons    = 0;
  logic [2:0] last_sel = '0;

  mode_select_ctrl #(
    .NUM_MODES (NM),
    .TICK_DIV  (TD),
    .DEBOUNCE_N(DBN),
    .RESET_SEL (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .next_n     (next_n),
    .prev_n     (prev_n),
    .sel        (sel),
    .sel_changed(sel_changed),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping: every sel change must carry a pulse and every pulse a change.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (sel_changed) pulse_cnt++;
      if ((sel !== last_sel) !== sel_changed) incons++;
    end
    last_sel = sel;
  end

  task automatic model_step(input int btn);
    if (btn == 0) model_sel = (model_sel + 1) % NM;
    else          model_sel = (model_sel + NM - 1) % NM;
  endtask

  task automatic press(input int btn, input int hold, input int gap);
    @(negedge clk);
    if (btn == 0) next_n = 1'b0; else prev_n = 1'b0;
    repeat (hold) @(negedge clk);
    next_n = 1'b1;
    prev_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
    checks++;
    if (sel_changed !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", sel_changed); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
  endtask

  task automatic test_tick;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tick !== ((n % TD) == 0)) begin
        errors++;
        $display("FAIL tick_cycle%0d: got %b want %b", n, tick, (n % TD) == 0);
      end
    end
    checks++;
    if (sel !== 3'd0) begin errors++; $display("FAIL idle_sel: got %0d want 0", sel); end
    checks++;
    if (pulse_cnt !== 0) begin errors++; $display("FAIL idle_pulses: got %0d want 0", pulse_cnt); end
  endtask

  task automatic test_next_wrap;
    int p;
    p = pulse_cnt;
    for (int k = 0; k < 5; k++) begin
      press(0, 24, 24);
      model_step(0);
      checks++;
      if (sel !== 3'(model_sel)) begin
        errors++;
        $display("FAIL next_press%0d: got %0d want %0d", k, sel, model_sel);
      end
    end
    checks++;
    if (pulse_cnt - p !== 5) begin errors++; $display("FAIL next_pulses: got %0d want 5", pulse_cnt - p); end
  endtask

  task automatic test_prev_wrap;
    int p;
    p = pulse_cnt;
    press(1, 24, 24);
    model_step(1);
    checks++;
    if (sel !== 3'(model_sel)) begin errors++; $display("FAIL prev_wrap: got %0d want %0d", sel, model_sel); end
    checks++;
    if (pulse_cnt - p !== 1) begin errors++; $display("FAIL prev_pulses: got %0d want 1", pulse_cnt - p); end
  endtask

  task automatic test_latency;
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    @(negedge clk);
    next_n = 1'b0;
    while (!found && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (sel_changed) found = 1'b1;
    end
    checks++;
    if (!found || n < (DBN - 1) * TD + 3 || n > DBN * TD + 3) begin
      errors++;
      $display("FAIL press_latency: got %0d cycles (seen=%b) want %0d..%0d",
               n, found, (DBN - 1) * TD + 3, DBN * TD + 3);
    end
    repeat (24 - n) @(negedge clk);
    next_n = 1'b1;
    repeat (24) @(negedge clk);
    model_step(0);
    checks++;
    if (sel !== 3'(model_sel)) begin errors++; $display("FAIL latency_sel: got %0d want %0d", sel, model_sel); end
  endtask

  task automatic test_glitch;
    int p, len, btn;
    for (int k = 0; k < 4; k++) begin
      p   = pulse_cnt;
      len = (k == 0) ? 4 : int'($urandom_range(1, 4));
      btn = (k == 0) ? 0 : int'($urandom_range(0, 1));
      press(btn, len, 24);
      checks++;
      if (sel !== 3'(model_sel) || pulse_cnt != p) begin
        errors++;
        $display("FAIL glitch%0d_len%0d: got sel %0d pulses %0d want sel %0d pulses 0",
                 k, len, sel, pulse_cnt - p, model_sel);
      end
    end
  endtask

  task automatic test_simultaneous;
    int p;
    p = pulse_cnt;
    @(negedge clk);
    next_n = 1'b0;
    prev_n = 1'b0;
    repeat (24) @(negedge clk);
    prev_n = 1'b1;
    repeat (24) @(negedge clk);
    next_n = 1'b1;
    repeat (24) @(negedge clk);
    checks++;
    if (sel !== 3'(model_sel) || pulse_cnt != p) begin
      errors++;
      $display("FAIL simultaneous_cancel: got sel %0d pulses %0d want sel %0d pulses 0",
               sel, pulse_cnt - p, model_sel);
    end
    press(1, 24, 24);
    model_step(1);
    checks++;
    if (sel !== 3'(model_sel)) begin errors++; $display("FAIL after_cancel: got %0d want %0d", sel, model_sel); end
  endtask

  task automatic test_hold_other;
    int p;
    p = pulse_cnt;
    @(negedge clk);
    next_n = 1'b0;
    repeat (24) @(negedge clk);
    model_step(0);
    checks++;
    if (sel !== 3'(model_sel)) begin errors++; $display("FAIL hold_first: got %0d want %0d", sel, model_sel); end
    prev_n = 1'b0;
    repeat (24) @(negedge clk);
    model_step(1);
    checks++;
    if (sel !== 3'(model_sel)) begin errors++; $display("FAIL hold_second: got %0d want %0d", sel, model_sel); end
    prev_n = 1'b1;
    repeat (24) @(negedge clk);
    next_n = 1'b1;
    repeat (24) @(negedge clk);
    checks++;
    if (sel !== 3'(model_sel) || pulse_cnt - p != 2) begin
      errors++;
      $display("FAIL hold_release: got sel %0d pulses %0d want sel %0d pulses 2",
               sel, pulse_cnt - p, model_sel);
    end
  endtask

  task automatic test_reset_hold;
    int p;
    @(negedge clk);
    next_n = 1'b0;
    repeat (24) @(negedge clk);
    model_step(0);
    checks++;
    if (sel !== 3'(model_sel)) begin errors++; $display("FAIL prereset_step: got %0d want %0d", sel, model_sel); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sel !== 3'd0 || sel_changed !== 1'b0) begin
      errors++;
      $display("FAIL midhold_reset: got sel %0d pulse %b want sel 0 pulse 0", sel, sel_changed);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_sel = 0;
    p = pulse_cnt;
    repeat (30) @(negedge clk);
    model_step(0);
    checks++;
    if (sel !== 3'(model_sel) || pulse_cnt - p != 1) begin
      errors++;
      $display("FAIL held_through_reset: got sel %0d pulses %0d want sel %0d pulses 1",
               sel, pulse_cnt - p, model_sel);
    end
    next_n = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic test_random;
    int p, btn, hold, gap, cnt;
    p   = pulse_cnt;
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      btn  = int'($urandom_range(0, 1));
      hold = int'($urandom_range(16, 40));
      gap  = int'($urandom_range(16, 40));
      press(btn, hold, gap);
      model_step(btn);
      cnt++;
      checks++;
      if (sel !== 3'(model_sel)) begin
        errors++;
        $display("FAIL random%0d btn%0d hold%0d: got %0d want %0d", k, btn, hold, sel, model_sel);
      end
    end
    checks++;
    if (pulse_cnt - p != cnt) begin
      errors++;
      $display("FAIL random_pulses: got %0d want %0d", pulse_cnt - p, cnt);
    end
  endtask

  task automatic test_pulse_consistency;
    checks++;
    if (incons != 0) begin
      errors++;
      $display("FAIL pulse_vs_change: got %0d inconsistent cycles want 0", incons);
    end
  endtask

  initial begin
    test_reset;
    test_tick;
    test_next_wrap;
    test_prev_wrap;
    test_latency;
    test_glitch;
    test_simultaneous;
    test_hold_other;
    test_reset_hold;
    test_random;
    test_pulse_consistency;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
